// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the multi-pass shift sequencer: op encodings,
// FSM state type, per-pass limit and the effective-amount rule.
package shift_seq_ctrl_pkg;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [2:0] MAX_STEP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Rotates wrap modulo 8; every other op saturates at a full 8-bit shift.
  function automatic logic [3:0] eff_amount(input logic [4:0] amt, input logic [1:0] op);
    if (op == OP_ROR) return {1'b0, amt[2:0]};
    else if (amt > 5'd8) return 4'd8;
    else return amt[3:0];
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_shift_step.sv
// Single combinational shift pass of 0..7 positions; the only shift
// datapath in the sequencer.
module shift_step
  import shift_seq_ctrl_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic [2:0] amt_i,
  input  logic [1:0] op_i,
  output logic [7:0] data_o
);

  logic [7:0] sra_res;

  assign sra_res = $unsigned($signed(data_i) >>> amt_i);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SRL:  data_o = data_i >> amt_i;
      OP_SLL:  data_o = data_i << amt_i;
      OP_SRA:  data_o = sra_res;
      OP_ROR:  data_o = (data_i >> amt_i) | (data_i << (4'd8 - {1'b0, amt_i}));
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequenced 8-bit shifter: captures an operand on start, applies the
// requested shift in passes of at most MAX_STEP bits, then pulses done.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [4:0] amt,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output state_e     state_o
);

  // Handshake: start is sampled only in IDLE and accepted on that edge;
  // busy is high from the accepting edge until the return to IDLE; done is
  // a one-cycle pulse in DONE with result valid, and result then holds
  // until the next accepted start. start while busy is dropped, not queued.

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] op_q, op_d;
  logic [2:0] step;
  logic [3:0] eff;
  logic [7:0] shifted;

  assign step = (rem_q > {1'b0, MAX_STEP}) ? MAX_STEP : rem_q[2:0];
  assign eff  = eff_amount(amt, op);

  shift_step u_shift_step (
    .data_i (acc_q),
    .amt_i  (step),
    .op_i   (op_q),
    .data_o (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= 8'h00;
      rem_q   <= 4'd0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = a;
          op_d    = op;
          rem_d   = eff;
          state_d = (eff != 4'd0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        acc_d = shifted;
        rem_d = rem_q - {1'b0, step};
        if (rem_q == {1'b0, step}) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Both flags decode registered state only, so no input reaches them combinationally.
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign result  = acc_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed vector table, hand-written reset
// sequences and randomized requests checked against an arithmetic model.
module tb_shift_seq_ctrl;
  import shift_seq_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [4:0] amt;
  logic [1:0] op;
  logic       busy;
  logic       done;
  logic [7:0] result;
  state_e     dbg_state;

  int vec_cnt;
  int err_cnt;

  typedef struct {
    logic [7:0] a;
    logic [4:0] amt;
    logic [1:0] op;
    logic [7:0] exp_res;
    int         exp_passes;
    bit         noisy;
  } vec_t;

  vec_t vecs[$];

  shift_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .amt     (amt),
    .op      (op),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: whole-amount arithmetic on integers, no pass splitting.
  task automatic model(input logic [7:0] ma, input logic [4:0] mamt, input logic [1:0] mop,
                       output logic [7:0] res, output int passes);
    int e, av, sv, r;
    av = int'(ma);
    if (mop == 2'b11) e = int'(mamt) % 8;
    else e = (int'(mamt) > 8) ? 8 : int'(mamt);
    passes = (e + 6) / 7;
    case (mop)
      2'b00: r = av / (1 << e);
      2'b01: r = (av * (1 << e)) % 256;
      2'b10: begin
        sv = (av >= 128) ? av - 256 : av;
        r  = (sv >>> e) & 255;
      end
      default: r = ((av >> e) | (av << (8 - e))) & 255;
    endcase
    res = r[7:0];
  endtask

  // driver: one request, optionally hammering start and operands while busy
  task automatic run_req(input logic [7:0] ta, input logic [4:0] tamt, input logic [1:0] top,
                         input logic [7:0] er, input int ep, input bit noisy, input string nm);
    int n;
    @(negedge clk);
    a = ta; amt = tamt; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = noisy;
    n = 0;
    while (!done && n < 6) begin
      a = 8'($urandom); amt = 5'($urandom); op = 2'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " passes"}, 32'(n), 32'(ep));
    chk({nm, " busy_at_done"}, 32'(busy), 32'd1);
    chk({nm, " result"}, 32'(result), 32'(er));
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " done_single"}, 32'(done), 32'd0);
    chk({nm, " idle_after"}, 32'(busy), 32'd0);
    chk({nm, " result_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic [7:0] mres;
    int         mp;
    vec_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; amt = 5'd0; op = 2'b00;

    vecs.push_back('{8'hB4, 5'd3,  OP_SRL, 8'h16, 1, 1'b0});
    vecs.push_back('{8'h81, 5'd8,  OP_SRA, 8'hFF, 2, 1'b0});
    vecs.push_back('{8'h81, 5'd8,  OP_SRL, 8'h00, 2, 1'b0});
    vecs.push_back('{8'h96, 5'd19, OP_ROR, 8'hD2, 1, 1'b0});
    vecs.push_back('{8'h96, 5'd31, OP_SLL, 8'h00, 2, 1'b0});
    vecs.push_back('{8'h5A, 5'd0,  OP_SRL, 8'h5A, 0, 1'b0});
    vecs.push_back('{8'h5A, 5'd0,  OP_SLL, 8'h5A, 0, 1'b0});
    vecs.push_back('{8'h5A, 5'd0,  OP_SRA, 8'h5A, 0, 1'b0});
    vecs.push_back('{8'h5A, 5'd0,  OP_ROR, 8'h5A, 0, 1'b0});
    vecs.push_back('{8'hC3, 5'd8,  OP_ROR, 8'hC3, 0, 1'b0});
    vecs.push_back('{8'h7F, 5'd5,  OP_SRA, 8'h03, 1, 1'b0});
    vecs.push_back('{8'h01, 5'd7,  OP_SLL, 8'h80, 1, 1'b0});
    vecs.push_back('{8'hB4, 5'd3,  OP_SRL, 8'h16, 1, 1'b1});
    vecs.push_back('{8'h81, 5'd8,  OP_SRA, 8'hFF, 2, 1'b1});
    vecs.push_back('{8'h5A, 5'd0,  OP_ROR, 8'h5A, 0, 1'b1});

    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'h00);
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_req(vecs[i].a, vecs[i].amt, vecs[i].op, vecs[i].exp_res,
              vecs[i].exp_passes, vecs[i].noisy, $sformatf("vec%0d", i));

    // reset dropped during the second pass of an 8-bit shift
    @(negedge clk);
    a = 8'h81; amt = 5'd8; op = OP_SRA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    chk("mid busy before abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", 32'(result), 32'h00);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort no done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_req(8'h01, 5'd1, OP_SLL, 8'h02, 1, 1'b0, "post_abort");

    // start held high across reset release
    @(negedge clk);
    rst_n = 1'b0;
    a = 8'h3C; amt = 5'd2; op = OP_SLL; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("release accept busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("release done", 32'(done), 32'd1);
    chk("release result", 32'(result), 32'hF0);
    @(posedge clk); #1;
    chk("release idle", 32'(busy), 32'd0);

    // randomized requests against the model
    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra;
      logic [4:0] ramt;
      logic [1:0] rop;
      ra = 8'($urandom); ramt = 5'($urandom_range(0, 31)); rop = 2'($urandom_range(0, 3));
      model(ra, ramt, rop, mres, mp);
      run_req(ra, ramt, rop, mres, mp, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
